// File: rtl/vga_timing_gen_if.sv
// Raster timing bus from vga_timing_gen to the renderer / colour output stage.
// The generator drives it through the master modport; consumers use slave.
interface vga_timing_gen_if #(
  parameter int CW  = 10,
  parameter int FCW = 16
);
  logic [CW-1:0]  px;
  logic [CW-1:0]  py;
  logic           hsync;
  logic           vsync;
  logic           display_on;
  logic           line_start;
  logic           frame_start;
  logic           vblank_start;
  logic [FCW-1:0] frame_cnt;

  modport master (
    output px, py, hsync, vsync, display_on,
    output line_start, frame_start, vblank_start, frame_cnt
  );

  modport slave (
    input px, py, hsync, vsync, display_on,
    input line_start, frame_start, vblank_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator clocked from the system clock
// with a pixel-tick enable; decode register plus PIPE_DLY alignment stages.
module vga_timing_gen #(
  parameter int   CW        = 10,
  parameter int   H_VISIBLE = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   PIPE_DLY  = 0,
  parameter int   FCW       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pix_en,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // One extra bit so boundaries equal to 2^CW compare correctly.
  localparam logic [CW:0] H_VIS = (CW+1)'(H_VISIBLE);
  localparam logic [CW:0] H_SS  = (CW+1)'(H_VISIBLE + H_FP);
  localparam logic [CW:0] H_SE  = (CW+1)'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW:0] H_END = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_VIS = (CW+1)'(V_VISIBLE);
  localparam logic [CW:0] V_SS  = (CW+1)'(V_VISIBLE + V_FP);
  localparam logic [CW:0] V_SE  = (CW+1)'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [CW:0] V_END = (CW+1)'(V_TOTAL - 1);

  typedef struct packed {
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          hs;
    logic          vs;
    logic          de;
    logic          ls;
    logic          fs;
    logic          vb;
  } sample_t;

  localparam sample_t IDLE = '{px: '0, py: '0, hs: ~HS_POL, vs: ~VS_POL,
                               de: 1'b0, ls: 1'b0, fs: 1'b0, vb: 1'b0};

  logic [CW-1:0]  hcount;
  logic [CW-1:0]  vcount;
  logic [FCW-1:0] frame_cnt_q;
  logic [CW:0]    h_ext;
  logic [CW:0]    v_ext;
  logic           load_q;
  sample_t        dec;
  sample_t        pipe [0:PIPE_DLY];
  sample_t        last;

  assign h_ext = {1'b0, hcount};
  assign v_ext = {1'b0, vcount};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_cnt_q <= '0;
    end else if (pix_en) begin
      if (h_ext == H_END) begin
        hcount <= '0;
        if (v_ext == V_END) begin
          vcount      <= '0;
          frame_cnt_q <= frame_cnt_q + FCW'(1);
        end else begin
          vcount <= vcount + CW'(1);
        end
      end else begin
        hcount <= hcount + CW'(1);
      end
    end
  end

  always_comb begin
    dec    = IDLE;
    dec.px = hcount;
    dec.py = vcount;
    dec.hs = (h_ext >= H_SS && h_ext < H_SE) ? HS_POL : ~HS_POL;
    dec.vs = (v_ext >= V_SS && v_ext < V_SE) ? VS_POL : ~VS_POL;
    dec.de = (h_ext < H_VIS) && (v_ext < V_VIS);
    dec.ls = (hcount == '0);
    dec.fs = (hcount == '0) && (vcount == '0);
    dec.vb = (hcount == '0) && (v_ext == V_VIS);
  end

  // Stage 0 is the decode register; the rest only delay it. load_q marks
  // the clk right after an output-stage load, which is when strobes may show.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_q <= 1'b0;
      for (int unsigned i = 0; i <= PIPE_DLY; i++) pipe[i] <= IDLE;
    end else begin
      load_q <= pix_en;
      if (pix_en) begin
        pipe[0] <= dec;
        for (int unsigned i = 1; i <= PIPE_DLY; i++) pipe[i] <= pipe[i-1];
      end
    end
  end

  assign last = pipe[PIPE_DLY];

  assign vid.px           = last.px;
  assign vid.py           = last.py;
  assign vid.hsync        = last.hs;
  assign vid.vsync        = last.vs;
  assign vid.display_on   = last.de;
  assign vid.line_start   = last.ls & load_q;
  assign vid.frame_start  = last.fs & load_q;
  assign vid.vblank_start = last.vb & load_q;
  assign vid.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two generators on a small 16x10 raster (8/2/3/3, 6/1/2/1),
// one plain and one with PIPE_DLY=3 and active-high syncs, FCW=2.
module tb_vga_timing_gen;

  typedef struct {
    int px;
    int py;
    bit hs, vs, de, ls, fs, vb;
  } exp_t;

  logic clk;
  logic rst_n;
  logic pix_en;

  int checks   = 0;
  int failures = 0;

  vga_timing_gen_if #(.CW(5), .FCW(2)) v0 ();
  vga_timing_gen_if #(.CW(5), .FCW(2)) v1 ();

  vga_timing_gen #(
    .CW(5), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0), .FCW(2)
  ) dut0 (.clk(clk), .rst_n(rst_n), .pix_en(pix_en), .vid(v0));

  vga_timing_gen #(
    .CW(5), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(3), .FCW(2)
  ) dut1 (.clk(clk), .rst_n(rst_n), .pix_en(pix_en), .vid(v1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived raster: hsync on h 10..12, vsync on v 7..8, visible 8x6.
  function automatic exp_t mk(input int h, input int v, input bit hp, input bit vp);
    exp_t e;
    e.px = h;
    e.py = v;
    e.hs = (h >= 10 && h < 13) ? hp : !hp;
    e.vs = (v >= 7 && v < 9) ? vp : !vp;
    e.de = (h < 8) && (v < 6);
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    e.vb = (h == 0) && (v == 6);
    return e;
  endfunction

  function automatic exp_t idle(input bit hp, input bit vp);
    exp_t e;
    e = '{px: 0, py: 0, hs: !hp, vs: !vp, de: 1'b0, ls: 1'b0, fs: 1'b0, vb: 1'b0};
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input int px, input int py,
                     input bit hs, input bit vs, input bit de,
                     input bit ls, input bit fs, input bit vb);
    chk({tag, ".px"}, px, e.px);
    chk({tag, ".py"}, py, e.py);
    chk({tag, ".hsync"}, int'(hs), int'(e.hs));
    chk({tag, ".vsync"}, int'(vs), int'(e.vs));
    chk({tag, ".display_on"}, int'(de), int'(e.de));
    chk({tag, ".line_start"}, int'(ls), int'(e.ls));
    chk({tag, ".frame_start"}, int'(fs), int'(e.fs));
    chk({tag, ".vblank_start"}, int'(vb), int'(e.vb));
  endtask

  // Reference raster counter: pushes the expected output sample per tick.
  exp_t q0[$];
  exp_t q1[$];
  int   mh, mv, mfc;
  bit   ticked, in_rst, started;

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst_n) begin
      mh     <= 0;
      mv     <= 0;
      mfc    <= 0;
      ticked <= 1'b0;
      in_rst <= 1'b1;
      q0.delete();
      q1.delete();
      for (int i = 0; i < 3; i++) q1.push_back(idle(1'b1, 1'b1));
    end else begin
      in_rst <= 1'b0;
      ticked <= pix_en;
      if (pix_en) begin
        q0.push_back(mk(mh, mv, 1'b0, 1'b0));
        q1.push_back(mk(mh, mv, 1'b1, 1'b1));
        if (mh == 15) begin
          mh <= 0;
          if (mv == 9) begin
            mv  <= 0;
            mfc <= (mfc + 1) % 4;
          end else begin
            mv <= mv + 1;
          end
        end else begin
          mh <= mh + 1;
        end
      end
    end
  end

  // Monitor: pops one expectation per loaded output sample.
  exp_t e0, e1;
  int   de_cnt, vb_cnt;
  bit   stat_valid;

  always @(negedge clk) begin
    if (started) begin
      if (in_rst) begin
        cmp("rst0", idle(1'b0, 1'b0), v0.px, v0.py, v0.hsync, v0.vsync, v0.display_on,
            v0.line_start, v0.frame_start, v0.vblank_start);
        cmp("rst1", idle(1'b1, 1'b1), v1.px, v1.py, v1.hsync, v1.vsync, v1.display_on,
            v1.line_start, v1.frame_start, v1.vblank_start);
        stat_valid = 1'b0;
      end else if (ticked) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty actual=%0d/%0d expected=nonempty", q0.size(), q1.size());
        end else begin
          e0 = q0.pop_front();
          e1 = q1.pop_front();
          cmp("d0", e0, v0.px, v0.py, v0.hsync, v0.vsync, v0.display_on,
              v0.line_start, v0.frame_start, v0.vblank_start);
          cmp("d1", e1, v1.px, v1.py, v1.hsync, v1.vsync, v1.display_on,
              v1.line_start, v1.frame_start, v1.vblank_start);
          if (v0.frame_start) begin
            if (stat_valid) begin
              chk("frame_display_ticks", de_cnt, 48);
              chk("frame_vblank_starts", vb_cnt, 1);
            end
            stat_valid = 1'b1;
            de_cnt = 0;
            vb_cnt = 0;
          end
          de_cnt += int'(v0.display_on);
          vb_cnt += int'(v0.vblank_start);
        end
      end else begin
        chk("gap_strobes0", int'({v0.line_start, v0.frame_start, v0.vblank_start}), 0);
        chk("gap_strobes1", int'({v1.line_start, v1.frame_start, v1.vblank_start}), 0);
      end
      chk("frame_cnt0", int'(v0.frame_cnt), mfc);
      chk("frame_cnt1", int'(v1.frame_cnt), mfc);
    end
  end

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    pix_en = 1'b1;

    // Five full frames at one tick per clk.
    repeat (800) @(posedge clk);
    #1;
    chk("frame_cnt_after_5", int'(v0.frame_cnt), 1);
    chk("d0_last_px", int'(v0.px), 15);
    chk("d0_last_py", int'(v0.py), 9);
    chk("d1_lag_px", int'(v1.px), 12);
    chk("d1_lag_hsync", int'(v1.hsync), 1);

    // Tick on every second clk, then a random duty cycle.
    for (int i = 0; i < 640; i++) begin
      pix_en = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 200; i++) begin
      pix_en = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end

    // Mid-frame reset with pix_en high; reset must win.
    pix_en = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_px", int'(v0.px), 0);
    chk("post_rst_py", int'(v0.py), 0);
    chk("post_rst_frame_start", int'(v0.frame_start), 1);
    chk("post_rst_line_start", int'(v0.line_start), 1);
    chk("post_rst_frame_cnt", int'(v0.frame_cnt), 0);
    chk("post_rst_d1_frame_start", int'(v1.frame_start), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_d1_fs_late", int'(v1.frame_start), 1);
    chk("post_rst_d1_px", int'(v1.px), 0);
    chk("post_rst_d0_px", int'(v0.px), 3);

    repeat (400) @(posedge clk);
    #1;
    pix_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
